// File: rtl/psum_acc_relu_x12.sv
// 12-lane partial-sum accumulator with saturating adds, ReLU/shift requantization
// and a lane-serial valid/ready output drain.
module psum_acc_relu_x12 #(
  parameter int unsigned SHIFT = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         psum_valid,
  input  logic [167:0] psum_in,
  input  logic         pass_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic [3:0]   out_lane,
  output logic         busy,
  output logic         ovf
);

  localparam int LANES = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic signed [17:0] acc_q [LANES];
  logic signed [17:0] acc_d [LANES];
  logic signed [13:0] lane_v [LANES];
  logic [3:0]         lane_q, lane_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               accept_s, xfer_s, drop_s;

  function automatic logic signed [17:0] sat_add(input logic signed [17:0] a,
                                                 input logic signed [13:0] b);
    logic signed [18:0] s;
    s = $signed({a[17], a}) + $signed({{5{b[13]}}, b});
    if (s > 19'sd131071) begin
      return 18'sd131071;
    end else if (s < -19'sd131072) begin
      return -18'sd131072;
    end else begin
      return $signed(s[17:0]);
    end
  endfunction

  // ReLU, truncating arithmetic shift, then clamp to the 8-bit activation range.
  function automatic logic [7:0] requant(input logic signed [17:0] a);
    logic signed [17:0] r;
    r = a >>> SHIFT;
    if (a < 18'sd0) begin
      return 8'd0;
    end else if (r > 18'sd255) begin
      return 8'd255;
    end else begin
      return r[7:0];
    end
  endfunction

  assign accept_s = psum_valid && en && (state_q != S_OUT);
  assign drop_s   = psum_valid && en && (state_q == S_OUT);
  assign xfer_s   = valid_q && out_ready;

  // Next-state, accumulator update and the registered view of the next output.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ovf_d   = ovf_q | drop_s;
    for (int k = 0; k < LANES; k++) begin
      lane_v[k] = $signed(psum_in[167-14*k -: 14]);
      acc_d[k]  = acc_q[k];
      if (accept_s) begin
        if (state_q == S_IDLE) begin
          acc_d[k] = {{4{lane_v[k][13]}}, lane_v[k]};
        end else begin
          acc_d[k] = sat_add(acc_q[k], lane_v[k]);
        end
      end else begin
        acc_d[k] = acc_q[k];
      end
    end

    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept_s && pass_last) begin
          state_d = S_OUT;
          lane_d  = 4'd0;
        end else if (accept_s) begin
          state_d = S_ACC;
        end else begin
          state_d = state_q;
        end
      end
      S_OUT: begin
        if (xfer_s && (lane_q == 4'd11)) begin
          state_d = S_IDLE;
          lane_d  = 4'd0;
        end else if (xfer_s) begin
          lane_d = lane_q + 4'd1;
        end else begin
          lane_d = lane_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        lane_d  = 4'd0;
      end
    endcase

    valid_d = (state_d == S_OUT);
    busy_d  = (state_d == S_OUT);
    if (state_d == S_OUT) begin
      data_d = requant(acc_d[lane_d]);
    end else begin
      data_d = 8'd0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= 18'sd0;
      end
      lane_q  <= 4'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      lane_q  <= lane_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_lane  = lane_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_psum_acc_relu_x12.sv
// Bench for psum_acc_relu_x12: directed scenarios plus randomized rows checked
// against an integer-arithmetic model of accumulate / saturate / requantize.
module tb_psum_acc_relu_x12;

  localparam int SHIFT = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         psum_valid;
  logic [167:0] psum_in;
  logic         pass_last;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_lane;
  logic         busy;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int col_vals [32][12];
  int exp_out [12];
  int got_data [12];
  int got_lane [12];
  int got_n;

  psum_acc_relu_x12 #(.SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .psum_valid(psum_valid), .psum_in(psum_in),
    .pass_last(pass_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_in();
    for (int i = 0; i < 12; i++) psum_in[167-14*i -: 14] = 14'($urandom());
  endtask

  task automatic drive_col(input int p);
    logic [13:0] t;
    for (int k = 0; k < 12; k++) begin
      t = col_vals[p][k][13:0];
      psum_in[167-14*k -: 14] = t;
    end
  endtask

  task automatic send_col(input int p, input bit last);
    drive_col(p);
    psum_valid = 1'b1; en = 1'b1; pass_last = last;
    tick();
    psum_valid = 1'b0; en = 1'b0; pass_last = 1'b0;
  endtask

  // Feeds npass columns; optional ignored (en=0) garbage cycles between them.
  task automatic apply_row(input int npass, input bit gaps);
    for (int p = 0; p < npass; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          garbage_in();
          psum_valid = 1'b1; en = 1'b0; pass_last = 1'($urandom_range(0, 1));
          tick();
        end
        psum_valid = 1'b0; pass_last = 1'b0;
      end
      send_col(p, p == npass - 1);
    end
  endtask

  function automatic void model_row(input int npass);
    int a;
    for (int k = 0; k < 12; k++) begin
      a = 0;
      for (int p = 0; p < npass; p++) begin
        a = a + col_vals[p][k];
        if (a > 131071) a = 131071;
        if (a < -131072) a = -131072;
      end
      if (a < 0) exp_out[k] = 0;
      else exp_out[k] = (a / (1 << SHIFT) > 255) ? 255 : a / (1 << SHIFT);
    end
  endfunction

  function automatic int rnd_lane();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // Collects 12 transfers; optionally injects an enabled column on the lane-11 transfer.
  task automatic drain(input bit rnd_ready, input bit poke11);
    int cyc = 0;
    got_n = 0;
    for (int i = 0; i < 12; i++) begin got_data[i] = -1; got_lane[i] = -1; end
    while (got_n < 12 && cyc < 200) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        got_data[got_n] = int'(out_data);
        got_lane[got_n] = int'(out_lane);
        got_n++;
        if (poke11 && out_lane == 4'd11) begin
          garbage_in();
          psum_valid = 1'b1; en = 1'b1; pass_last = 1'b0;
        end
      end
      tick();
      psum_valid = 1'b0; en = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_row(input string name, input bit use_const, input int cval);
    int want;
    n_cmp++;
    if (got_n !== 12) begin
      n_bad++;
      $display("FAIL %s transfers: got %0d want 12", name, got_n);
    end
    for (int i = 0; i < 12; i++) begin
      want = use_const ? cval : exp_out[i];
      n_cmp++;
      if (got_lane[i] !== i || got_data[i] !== want) begin
        n_bad++;
        $display("FAIL %s beat%0d: lane %0d data %0d, want lane %0d data %0d",
                 name, i, got_lane[i], got_data[i], i, want);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle-after: busy %b out_valid %b, want 0 0", name, busy, out_valid);
    end
  endtask

  task automatic fill_const(input int p, input int v);
    for (int k = 0; k < 12; k++) col_vals[p][k] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; psum_valid = 1'b0; pass_last = 1'b0; out_ready = 1'b0;
    psum_in = '0;
    repeat (3) tick();
    garbage_in(); psum_valid = 1'b1; en = 1'b1; pass_last = 1'b1;
    tick();
    psum_valid = 1'b0; en = 1'b0; pass_last = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_lane, busy, ovf} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_values: v%b d%0d l%0d b%b o%b, want all 0",
               out_valid, out_data, out_lane, busy, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    fill_const(0, 640);
    send_col(0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_lane !== 4'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_first: valid %b lane %0d busy %b, want 1 0 1", out_valid, out_lane, busy);
    end
    drain(1'b0, 1'b0);
    check_row("single_pass", 1'b1, 10);
  endtask

  task automatic test_multi_pass();
    for (int k = 0; k < 12; k++) col_vals[0][k] = rnd_lane();
    apply_row(1, 1'b0);
    drain(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) fill_const(p, 64);
    apply_row(3, 1'b1);
    drain(1'b1, 1'b0);
    check_row("multi_pass", 1'b1, 3);
  endtask

  task automatic test_relu_clamp();
    for (int p = 0; p < 17; p++) begin
      fill_const(p, 0);
      col_vals[p][0] = (p < 2) ? -8192 : 0;
      col_vals[p][1] = 8191;
      col_vals[p][2] = (p == 0) ? 100 : 0;
    end
    model_row(17);
    apply_row(17, 1'b0);
    drain(1'b0, 1'b0);
    check_row("relu_clamp", 1'b0, 0);
    n_cmp++;
    if (got_data[0] !== 0 || got_data[1] !== 255 || got_data[2] !== 1) begin
      n_bad++;
      $display("FAIL relu_clamp_lanes: %0d %0d %0d, want 0 255 1", got_data[0], got_data[1], got_data[2]);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    int stall = 0;
    int n3 = 0;
    for (int k = 0; k < 12; k++) col_vals[0][k] = int'($urandom_range(0, 8191));
    model_row(1);
    apply_row(1, 1'b0);
    got_n = 0;
    while (got_n < 12 && cyc < 200) begin
      if (out_valid && out_lane == 4'd3 && stall < 5) begin
        out_ready = 1'b0;
        n_cmp++;
        if (out_lane !== 4'd3 || int'(out_data) !== exp_out[3]) begin
          n_bad++;
          $display("FAIL backpressure_hold%0d: lane %0d data %0d, want 3 %0d",
                   stall, out_lane, out_data, exp_out[3]);
        end
        stall++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          got_data[got_n] = int'(out_data);
          got_lane[got_n] = int'(out_lane);
          got_n++;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check_row("backpressure", 1'b0, 0);
    for (int i = 0; i < 12; i++) if (got_lane[i] == 3) n3++;
    n_cmp++;
    if (n3 !== 1 || stall !== 5) begin
      n_bad++;
      $display("FAIL backpressure_once: lane3 count %0d stalls %0d, want 1 5", n3, stall);
    end
  endtask

  task automatic test_random();
    int np;
    for (int r = 0; r < 8; r++) begin
      np = (r % 2 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 20));
      for (int p = 0; p < np; p++)
        for (int k = 0; k < 12; k++)
          col_vals[p][k] = ($urandom_range(0, 3) == 0) ?
                           (($urandom_range(0, 1) == 1) ? 8191 : -8192) :
                           (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8191)) : rnd_lane());
      model_row(np);
      apply_row(np, 1'b1);
      drain(1'b1, 1'b0);
      check_row("random_row", 1'b0, 0);
    end
  endtask

  task automatic test_overflow_enable();
    for (int k = 0; k < 12; k++) begin
      col_vals[0][k] = int'($urandom_range(0, 4000));
      col_vals[1][k] = int'($urandom_range(0, 4000));
    end
    model_row(2);
    send_col(0, 1'b0);
    repeat (3) begin
      garbage_in(); psum_valid = 1'b1; en = 1'b0; pass_last = 1'b1;
      tick();
    end
    psum_valid = 1'b0; pass_last = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL en0_ignored: ovf %b busy %b, want 0 0", ovf, busy);
    end
    out_ready = 1'b0;
    send_col(1, 1'b1);
    garbage_in(); psum_valid = 1'b1; en = 1'b1; pass_last = 1'b1;
    tick();
    psum_valid = 1'b0; en = 1'b0; pass_last = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || busy !== 1'b1 || out_lane !== 4'd0) begin
      n_bad++;
      $display("FAIL ovf_drop: ovf %b busy %b lane %0d, want 1 1 0", ovf, busy, out_lane);
    end
    drain(1'b0, 1'b1);
    check_row("ovf_row", 1'b0, 0);
    fill_const(0, 640);
    send_col(0, 1'b1);
    drain(1'b0, 1'b0);
    check_row("after_lane11_drop", 1'b1, 10);
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: ovf %b, want 1", ovf);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    fill_const(0, 640);
    send_col(0, 1'b1);
    out_ready = 1'b1;
    while (!(out_valid && out_lane == 4'd5) && cyc < 50) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (out_lane !== 4'd5) begin
      n_bad++;
      $display("FAIL reset_mid_reach: lane %0d, want 5", out_lane);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_lane, busy, ovf} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async: v%b d%0d l%0d b%b o%b, want all 0",
               out_valid, out_data, out_lane, busy, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    send_col(0, 1'b1);
    drain(1'b0, 1'b0);
    check_row("reset_mid_next", 1'b1, 10);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_relu_clamp();
    test_backpressure();
    test_random();
    test_overflow_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psum_acc_relu_x12.md
PSUM_ACC_RELU_X12 -- requirements
Module: psum_acc_relu_x12

Interface
REQ-001 The block SHALL have parameter SHIFT, default 6: requantization right-shift amount, legal range 0..10.
REQ-002 Port clk, input, 1 bit: single clock for all state.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port en, input, 1 bit: array advance enable; accumulation occurs only when en=1.
REQ-005 Port psum_valid, input, 1 bit: psum_in carries one valid 12-lane partial-sum column this cycle.
REQ-006 Port psum_in, input, 168 bits: 12 signed 14-bit lanes; lane k = psum_in[167-14k -: 14], so lane 0 = [167:154] and lane 11 = [13:0].
REQ-007 Port pass_last, input, 1 bit: qualifies psum_valid; the column is the final input-channel pass for this output row.
REQ-008 Port out_valid, output, 1 bit: out_data holds a valid requantized pixel.
REQ-009 Port out_ready, input, 1 bit: consumer accepts out_data; a transfer occurs when out_valid=1 and out_ready=1.
REQ-010 Port out_data, output, 8 bits: unsigned activation.
REQ-011 Port out_lane, output, 4 bits: lane index 0..11 of out_data.
REQ-012 Port busy, output, 1 bit: high in the OUT state.
REQ-013 Port ovf, output, 1 bit: sticky flag, set when a column is dropped.

Function
REQ-014 The block SHALL hold 12 signed 18-bit accumulators acc[0..11] and a state machine with states IDLE, ACC and OUT.
REQ-015 An accept SHALL be defined as psum_valid=1 and en=1 while the state is IDLE or ACC.
REQ-016 An accept in IDLE SHALL load acc[k] = sign-extend(lane k), not add to it.
REQ-017 An accept in ACC SHALL set acc[k] = acc[k] + sign-extend(lane k).
REQ-018 The addition result SHALL saturate to the range -131072..131071 and SHALL NOT wrap.
REQ-019 Transitions: IDLE->ACC on an accept with pass_last=0; IDLE or ACC ->OUT on an accept with pass_last=1; OUT->IDLE on the transfer of lane 11; all other cases hold state.
REQ-020 When pass_last=1 is accepted at edge t, the block SHALL show out_valid=1 with out_lane=0 after edge t, so the column's own contribution is included.
REQ-021 In OUT, out_valid SHALL be 1 and out_data SHALL be the requantized acc[out_lane].
REQ-022 Requantization SHALL be: r = (acc<0) ? 0 : (acc >>> SHIFT); out_data = (r>255) ? 255 : r[7:0].
REQ-023 Requantization SHALL truncate and SHALL NOT round.
REQ-024 Each transfer SHALL increment out_lane by 1.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_lane SHALL stay stable.
REQ-026 en SHALL NOT gate the output handshake; draining proceeds even when en=0.
REQ-027 psum_valid=1 with en=1 in OUT SHALL drop the column, set ovf=1, and leave acc unchanged.
REQ-028 ovf SHALL clear only on reset.
REQ-029 psum_valid with en=0 SHALL be ignored in every state and SHALL NOT set ovf.
REQ-030 A transfer of lane 11 and a psum_valid in the same cycle: the column SHALL be dropped and ovf set, because the state is still OUT.
REQ-031 The block SHALL never present out_valid=1 outside the OUT state.
REQ-032 busy SHALL equal (state==OUT).

Reset
REQ-033 While rst_n=0, the block SHALL immediately and asynchronously force: state=IDLE, acc[*]=0, out_valid=0, out_data=0, out_lane=0, busy=0, ovf=0.
REQ-034 Reset asserted mid-ACC or mid-OUT SHALL discard all partial sums and pending output without emitting further transfers.
REQ-035 After rst_n rises, the first accept SHALL load as in REQ-016.

Verification (SHIFT=6)
REQ-036 Single-pass row: one accept with pass_last=1 and every lane = 640, out_ready=1 -> out_valid high on the next cycle; 12 transfers with out_lane 0..11, each out_data=10; then IDLE and busy=0.
REQ-037 Multi-pass accumulation: three accepts with lane k = 64 each and pass_last only on the third -> all outputs 3; the bench SHALL also check IDLE-load by preloading garbage from a previous row.
REQ-038 ReLU and clamp: lane 0 = -8192 over 2 passes -> 0; lane 1 = 8191 over 17 passes (acc saturates at 131071) -> 255; lane 2 = 100 -> 1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles at out_lane=3 -> out_data and out_lane stay stable, and lane 3 is emitted exactly once.
REQ-040 Overflow and enable: psum_valid=1 with en=1 during OUT -> ovf=1 and remaining outputs unchanged; psum_valid=1 with en=0 in ACC -> acc unchanged and ovf unchanged.
REQ-041 Reset mid-operation: assert rst_n=0 at out_lane=5 -> out_valid=0 immediately and all outputs at reset values; the next single-pass row of 640 yields all 10.
